hazard_ctrl_p: RTL and testbench

- Parametrised load-use hazard controller for the CPU pipeline; successor to the single-cycle, single-load hazard check.
- Tracks in-flight loads in a LOAD_LAT-deep shift scoreboard, because memory latency is now configurable.
- Stalls decode while any used source register matches a pending load destination; holds PC and injects an EX bubble.
- Supports branch flush, optional hardwired zero register, and saturating stall statistics.

---
 rtl/hazard_ctrl_p.sv | 92 +++++++++
 tb/tb_hazard_ctrl_p.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_p.sv
// Load-use hazard controller: stalls decode while a source register waits on an
// in-flight load tracked in a LOAD_LAT-deep shift scoreboard; flush always wins.
module hazard_ctrl_p #(
    parameter int PC_W     = 8,
    parameter int REG_W    = 4,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc,
    input  logic [PC_W-1:0]    pc_next,
    input  logic               id_valid,
    input  logic               id_mem_rd,
    input  logic [REG_W-1:0]   id_dest,
    input  logic [REG_W-1:0]   id_src1,
    input  logic [REG_W-1:0]   id_src2,
    input  logic               id_src1_used,
    input  logic               id_src2_used,
    input  logic               flush,
    output logic               hazard,
    output logic [PC_W-1:0]    new_pc,
    output logic               bubble,
    output logic [1:0]         hazard_src,
    output logic [3:0]         stall_run,
    output logic [CNT_W-1:0]   stall_total
);

    localparam bit ZR_EN = (ZERO_REG != 0);

    logic [LOAD_LAT-1:0] slot_vld;
    logic [REG_W-1:0]    slot_dst [LOAD_LAT];

    logic hit1;
    logic hit2;
    logic match1;
    logic match2;
    logic live;
    logic issue_ld;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (slot_vld[k] && (slot_dst[k] == id_src1)) hit1 = 1'b1;
            if (slot_vld[k] && (slot_dst[k] == id_src2)) hit2 = 1'b1;
        end
    end

    // Register 0 is hardwired when ZR_EN, so a pending load to it is harmless.
    assign match1 = id_src1_used & hit1 & ~(ZR_EN & (id_src1 == '0));
    assign match2 = id_src2_used & hit2 & ~(ZR_EN & (id_src2 == '0));

    assign live       = id_valid & ~flush;
    assign hazard_src = {match2, match1} & {2{live}};
    assign hazard     = |hazard_src;
    assign new_pc     = hazard ? pc : pc_next;
    assign bubble     = hazard | flush;
    assign issue_ld   = id_valid & id_mem_rd & ~hazard & ~flush;

    // Slots shift even while stalled so a single load never blocks longer than LOAD_LAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld <= '0;
            for (int k = 0; k < LOAD_LAT; k++) slot_dst[k] <= '0;
        end else begin
            slot_vld[0] <= issue_ld;
            slot_dst[0] <= id_dest;
            for (int k = 1; k < LOAD_LAT; k++) begin
                slot_vld[k] <= slot_vld[k-1];
                slot_dst[k] <= slot_dst[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_run   <= '0;
            stall_total <= '0;
        end else begin
            if (!hazard)
                stall_run <= '0;
            else if (stall_run != 4'hF)
                stall_run <= stall_run + 4'd1;

            if (hazard && (stall_total != {CNT_W{1'b1}}))
                stall_total <= stall_total + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Drives two hazard_ctrl_p configurations with shared stimulus and compares each
// against an issue-history model of pending loads.
module tb_hazard_ctrl_p;

    localparam int LAT_A = 3;
    localparam int ZR_A  = 1;
    localparam int CW_A  = 16;
    localparam int LAT_B = 1;
    localparam int ZR_B  = 0;
    localparam int CW_B  = 4;
    localparam int MAXC  = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc = '0;
    logic [7:0] pc_next = '0;
    logic       id_valid = 1'b0;
    logic       id_mem_rd = 1'b0;
    logic [3:0] id_dest = '0;
    logic [3:0] id_src1 = '0;
    logic [3:0] id_src2 = '0;
    logic       id_src1_used = 1'b0;
    logic       id_src2_used = 1'b0;
    logic       flush = 1'b0;

    logic        hz_a, bub_a, hz_b, bub_b;
    logic [7:0]  npc_a, npc_b;
    logic [1:0]  hs_a, hs_b;
    logic [3:0]  run_a, run_b;
    logic [15:0] tot_a;
    logic [3:0]  tot_b;

    hazard_ctrl_p #(.PC_W(8), .REG_W(4), .LOAD_LAT(LAT_A), .ZERO_REG(ZR_A), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
        .id_valid(id_valid), .id_mem_rd(id_mem_rd), .id_dest(id_dest),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .flush(flush),
        .hazard(hz_a), .new_pc(npc_a), .bubble(bub_a), .hazard_src(hs_a),
        .stall_run(run_a), .stall_total(tot_a)
    );

    hazard_ctrl_p #(.PC_W(8), .REG_W(4), .LOAD_LAT(LAT_B), .ZERO_REG(ZR_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next),
        .id_valid(id_valid), .id_mem_rd(id_mem_rd), .id_dest(id_dest),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used), .flush(flush),
        .hazard(hz_b), .new_pc(npc_b), .bubble(bub_b), .hazard_src(hs_b),
        .stall_run(run_b), .stall_total(tot_b)
    );

    always #5 clk = ~clk;

    // Model: per configuration, which cycles issued a load and to which register.
    bit         iss [2][MAXC];
    logic [3:0] dst [2][MAXC];
    int run_m [2];
    int tot_m [2];
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A load issued in cycle t is unavailable during cycles t+1 .. t+lat.
    function automatic bit pending(int inst, int lat, logic [3:0] r);
        for (int t = cyc - lat; t < cyc; t++)
            if (t >= 0 && iss[inst][t] && dst[inst][t] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < MAXC; t++) iss[i][t] = 1'b0;
            run_m[i] = 0;
            tot_m[i] = 0;
        end
    endtask

    task automatic check_inst(input int inst, input bit upd);
        int lat, zr, tmax;
        bit m1, m2, eh;
        logic [1:0] es;
        logic hz_o, bub_o;
        logic [7:0] npc_o;
        logic [1:0] hs_o;
        logic [3:0] run_o;
        logic [15:0] tot_o;
        lat  = (inst == 0) ? LAT_A : LAT_B;
        zr   = (inst == 0) ? ZR_A : ZR_B;
        tmax = (inst == 0) ? ((1 << CW_A) - 1) : ((1 << CW_B) - 1);
        if (inst == 0) begin
            hz_o = hz_a; bub_o = bub_a; npc_o = npc_a; hs_o = hs_a; run_o = run_a; tot_o = tot_a;
        end else begin
            hz_o = hz_b; bub_o = bub_b; npc_o = npc_b; hs_o = hs_b; run_o = run_b; tot_o = {12'd0, tot_b};
        end
        m1 = id_src1_used && !(zr != 0 && id_src1 == 4'd0) && pending(inst, lat, id_src1);
        m2 = id_src2_used && !(zr != 0 && id_src2 == 4'd0) && pending(inst, lat, id_src2);
        es = (id_valid && !flush) ? {m2, m1} : 2'b00;
        eh = (es != 2'b00);
        check($sformatf("hazard%0d", inst),      {31'd0, hz_o},  {31'd0, eh});
        check($sformatf("hazard_src%0d", inst),  {30'd0, hs_o},  {30'd0, es});
        check($sformatf("new_pc%0d", inst),      {24'd0, npc_o}, {24'd0, (eh ? pc : pc_next)});
        check($sformatf("bubble%0d", inst),      {31'd0, bub_o}, {31'd0, (eh || flush)});
        check($sformatf("stall_run%0d", inst),   {28'd0, run_o}, run_m[inst]);
        check($sformatf("stall_total%0d", inst), {16'd0, tot_o}, tot_m[inst]);
        if (upd) begin
            iss[inst][cyc] = id_valid && id_mem_rd && !eh && !flush;
            dst[inst][cyc] = id_dest;
            run_m[inst] = eh ? ((run_m[inst] < 15) ? run_m[inst] + 1 : 15) : 0;
            if (eh && tot_m[inst] < tmax) tot_m[inst] = tot_m[inst] + 1;
        end
    endtask

    task automatic set_id(input bit v, input bit mr, input int d, input int s1, input int s2,
                          input bit u1, input bit u2, input bit fl);
        id_valid = v; id_mem_rd = mr; id_dest = 4'(d);
        id_src1 = 4'(s1); id_src2 = 4'(s2);
        id_src1_used = u1; id_src2_used = u2; flush = fl;
        pc = 8'($urandom); pc_next = 8'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        check_inst(0, 1'b1);
        check_inst(1, 1'b1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset asserted mid-cycle must release any stall before the next edge.
    task automatic mid_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_inst(0, 1'b0);
        check_inst(1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
    endtask

    initial begin
        model_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check_inst(0, 1'b0);
        check_inst(1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load r3, dependent src1=r3
        set_id(1, 1, 3, 0, 0, 0, 0, 0); step();
        set_id(1, 0, 4, 3, 1, 1, 0, 0); repeat (4) step();
        // Load r5, dependent src2=r5
        set_id(1, 1, 5, 0, 0, 0, 0, 0); step();
        set_id(1, 0, 6, 1, 5, 1, 1, 0); repeat (5) step();
        // Load r0, dependent on r0
        set_id(1, 1, 0, 0, 0, 0, 0, 0); step();
        set_id(1, 0, 6, 0, 2, 1, 0, 0); repeat (2) step();
        // Unused src matching, independent r7 use
        set_id(1, 1, 6, 0, 0, 0, 0, 0); step();
        set_id(1, 0, 8, 6, 7, 0, 1, 0); repeat (2) step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();
        // Flush on a matching cycle; load during flush is not recorded
        set_id(1, 1, 2, 0, 0, 0, 0, 0); step();
        set_id(1, 0, 8, 2, 0, 1, 0, 1); step();
        set_id(1, 1, 9, 0, 0, 0, 0, 1); step();
        set_id(1, 0, 8, 9, 9, 1, 1, 0); repeat (2) step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); repeat (3) step();
        // Reset during second cycle of a stall
        set_id(1, 1, 5, 0, 0, 0, 0, 0); step();
        set_id(1, 0, 8, 5, 0, 1, 0, 0); step();
        mid_reset();
        repeat (2) step();

        for (int i = 0; i < 1500; i++) begin
            set_id($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4,
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) mid_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
